// File: rtl/fetch_aligner.sv
// Aligns a 32-bit word fetch stream into RVC/RV32 instructions.
// A halfword buffer holds the upper half of a word so compressed and straddling instructions can be reassembled.
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_word,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_compressed,
  output logic        instr_valid,
  input  logic        instr_ready
);

  logic [15:0] hb_q, hb_d;
  logic [31:0] hb_pc_q, hb_pc_d;
  logic        hb_valid_q, hb_valid_d;
  logic        skip_low_q, skip_low_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_compressed_q, instr_compressed_d;
  logic        instr_valid_q, instr_valid_d;

  logic        load_en;
  logic        accept;
  logic        hb_comp;
  logic        word_comp;
  logic [31:0] upper_pc;
  logic [31:0] lower_pc;
  logic        unused_bits;

  assign unused_bits = ^{fetch_pc[1:0], flush_pc[0]};

  always_comb begin
    load_en   = !instr_valid_q || instr_ready;
    hb_comp   = hb_q[1:0] != 2'b11;
    word_comp = fetch_word[1:0] != 2'b11;
    upper_pc  = {fetch_pc[31:2], 2'b10};
    lower_pc  = {fetch_pc[31:2], 2'b00};

    // A word is taken only when the instruction it completes can be loaded,
    // except while dropping a low half, which never produces output.
    fetch_ready = 1'b0;
    if (!reset && !flush) begin
      if (hb_valid_q)
        fetch_ready = hb_comp ? 1'b0 : load_en;
      else if (skip_low_q)
        fetch_ready = 1'b1;
      else
        fetch_ready = load_en;
    end
    accept = fetch_valid && fetch_ready;

    hb_d               = hb_q;
    hb_pc_d            = hb_pc_q;
    hb_valid_d         = hb_valid_q;
    skip_low_d         = skip_low_q;
    instr_d            = instr_q;
    instr_pc_d         = instr_pc_q;
    instr_compressed_d = instr_compressed_q;
    instr_valid_d      = load_en ? 1'b0 : instr_valid_q;

    if (flush) begin
      instr_valid_d = 1'b0;
      hb_valid_d    = 1'b0;
      skip_low_d    = flush_pc[1];
    end else if (hb_valid_q) begin
      if (hb_comp) begin
        if (load_en) begin
          instr_d            = {16'h0000, hb_q};
          instr_pc_d         = hb_pc_q;
          instr_compressed_d = 1'b1;
          instr_valid_d      = 1'b1;
          hb_valid_d         = 1'b0;
        end
      end else if (accept) begin
        instr_d            = {fetch_word[15:0], hb_q};
        instr_pc_d         = hb_pc_q;
        instr_compressed_d = 1'b0;
        instr_valid_d      = 1'b1;
        hb_d               = fetch_word[31:16];
        hb_pc_d            = upper_pc;
      end
    end else if (skip_low_q) begin
      if (accept) begin
        hb_d       = fetch_word[31:16];
        hb_pc_d    = upper_pc;
        hb_valid_d = 1'b1;
        skip_low_d = 1'b0;
      end
    end else if (accept) begin
      instr_pc_d    = lower_pc;
      instr_valid_d = 1'b1;
      if (word_comp) begin
        instr_d            = {16'h0000, fetch_word[15:0]};
        instr_compressed_d = 1'b1;
        hb_d               = fetch_word[31:16];
        hb_pc_d            = upper_pc;
        hb_valid_d         = 1'b1;
      end else begin
        instr_d            = fetch_word;
        instr_compressed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hb_q               <= 16'h0000;
      hb_pc_q            <= 32'h0;
      hb_valid_q         <= 1'b0;
      skip_low_q         <= RESET_PC[1];
      instr_q            <= 32'h0;
      instr_pc_q         <= 32'h0;
      instr_compressed_q <= 1'b0;
      instr_valid_q      <= 1'b0;
    end else begin
      hb_q               <= hb_d;
      hb_pc_q            <= hb_pc_d;
      hb_valid_q         <= hb_valid_d;
      skip_low_q         <= skip_low_d;
      instr_q            <= instr_d;
      instr_pc_q         <= instr_pc_d;
      instr_compressed_q <= instr_compressed_d;
      instr_valid_q      <= instr_valid_d;
    end
  end

  assign instr            = instr_q;
  assign instr_pc         = instr_pc_q;
  assign instr_compressed = instr_compressed_q;
  assign instr_valid      = instr_valid_q;

endmodule

// File: tb/tb_fetch_aligner.sv
// Self-checking bench for fetch_aligner: directed scenarios plus a random
// stream checked against a halfword-queue model of the instruction stream.
module tb_fetch_aligner;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] fetch_word = 32'h0;
  logic [31:0] fetch_pc = 32'h0;
  logic        fetch_valid = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        instr_ready = 1'b0;

  logic        fetch_ready, fetch_ready2;
  logic [31:0] instr, instr2, instr_pc, instr_pc2;
  logic        instr_compressed, instr_compressed2;
  logic        instr_valid, instr_valid2;

  logic [65:0] obs, obs2, exp_v;
  assign obs  = {instr_valid, instr_compressed, instr_pc, instr};
  assign obs2 = {instr_valid2, instr_compressed2, instr_pc2, instr2};

  int vectors = 0;
  int miscompares = 0;

  fetch_aligner dut (
    .clk(clk), .reset(reset), .fetch_word(fetch_word), .fetch_pc(fetch_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .flush(flush),
    .flush_pc(flush_pc), .instr(instr), .instr_pc(instr_pc),
    .instr_compressed(instr_compressed), .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  fetch_aligner #(.RESET_PC(32'h0000_0002)) dut2 (
    .clk(clk), .reset(reset), .fetch_word(fetch_word), .fetch_pc(fetch_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready2), .flush(flush),
    .flush_pc(flush_pc), .instr(instr2), .instr_pc(instr_pc2),
    .instr_compressed(instr_compressed2), .instr_valid(instr_valid2),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  task automatic cycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1; flush = 1'b0; fetch_valid = 1'b0; instr_ready = 1'b0;
    cycle;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1; flush = 1'b0; fetch_valid = 1'b1; fetch_word = 32'h0000_0013;
    fetch_pc = 32'h0; instr_ready = 1'b1;
    #1;
    vectors++;
    if (fetch_ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_fetch_ready got %b exp 0", fetch_ready);
    end
    cycle;
    vectors++;
    if (obs !== 66'h0) begin
      miscompares++; $display("[TB] FAIL reset_outputs got %h exp 0", obs);
    end
    reset = 1'b0; fetch_valid = 1'b0;
  endtask

  task automatic test_uncompressed;
    do_reset;
    instr_ready = 1'b1; fetch_valid = 1'b1; fetch_word = 32'h0000_0013; fetch_pc = 32'h0;
    #1;
    vectors++;
    if (fetch_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL unc_ready got %b exp 1", fetch_ready);
    end
    cycle;
    exp_v = {1'b1, 1'b0, 32'h0, 32'h0000_0013};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++; $display("[TB] FAIL unc_first got %h exp %h", obs, exp_v);
    end
    fetch_word = 32'h0000_0093; fetch_pc = 32'h4;
    cycle;
    exp_v = {1'b1, 1'b0, 32'h4, 32'h0000_0093};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++; $display("[TB] FAIL unc_second got %h exp %h", obs, exp_v);
    end
    fetch_valid = 1'b0;
    cycle;
    vectors++;
    if (instr_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL unc_drain_valid got %b exp 0", instr_valid);
    end
  endtask

  task automatic test_compressed_pair;
    do_reset;
    instr_ready = 1'b1; fetch_valid = 1'b1; fetch_word = 32'h4505_4501; fetch_pc = 32'h0;
    cycle;
    exp_v = {1'b1, 1'b1, 32'h0, 32'h0000_4501};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++; $display("[TB] FAIL pair_low got %h exp %h", obs, exp_v);
    end
    fetch_word = 32'h0000_0013; fetch_pc = 32'h4;
    #1;
    vectors++;
    if (fetch_ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL pair_ready_hb got %b exp 0", fetch_ready);
    end
    cycle;
    exp_v = {1'b1, 1'b1, 32'h2, 32'h0000_4505};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++; $display("[TB] FAIL pair_high got %h exp %h", obs, exp_v);
    end
    #1;
    vectors++;
    if (fetch_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL pair_ready_next got %b exp 1", fetch_ready);
    end
    cycle;
    exp_v = {1'b1, 1'b0, 32'h4, 32'h0000_0013};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++; $display("[TB] FAIL pair_next got %h exp %h", obs, exp_v);
    end
    fetch_valid = 1'b0;
  endtask

  task automatic test_straddle;
    do_reset;
    instr_ready = 1'b1; fetch_valid = 1'b1; fetch_word = 32'h0013_4501; fetch_pc = 32'h0;
    cycle;
    exp_v = {1'b1, 1'b1, 32'h0, 32'h0000_4501};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++; $display("[TB] FAIL strad_first got %h exp %h", obs, exp_v);
    end
    fetch_word = 32'h4505_0000; fetch_pc = 32'h4;
    #1;
    vectors++;
    if (fetch_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL strad_ready got %b exp 1", fetch_ready);
    end
    cycle;
    exp_v = {1'b1, 1'b0, 32'h2, 32'h0000_0013};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++; $display("[TB] FAIL strad_join got %h exp %h", obs, exp_v);
    end
    fetch_valid = 1'b0;
    #1;
    vectors++;
    if (fetch_ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL strad_ready_hb got %b exp 0", fetch_ready);
    end
    cycle;
    exp_v = {1'b1, 1'b1, 32'h6, 32'h0000_4505};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++; $display("[TB] FAIL strad_tail got %h exp %h", obs, exp_v);
    end
  endtask

  task automatic test_flush_skip;
    flush = 1'b1; flush_pc = 32'h102; fetch_valid = 1'b1; fetch_word = 32'h1111_1111;
    fetch_pc = 32'h8; instr_ready = 1'b1;
    #1;
    vectors++;
    if (fetch_ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL flush_ready got %b exp 0", fetch_ready);
    end
    cycle;
    flush = 1'b0;
    vectors++;
    if (instr_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL flush_valid got %b exp 0", instr_valid);
    end
    fetch_word = 32'h0000_4501; fetch_pc = 32'h100;
    #1;
    vectors++;
    if (fetch_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL skip_ready got %b exp 1", fetch_ready);
    end
    cycle;
    vectors++;
    if (instr_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL skip_no_output got %b exp 0", instr_valid);
    end
    fetch_word = 32'h0000_0013; fetch_pc = 32'h104;
    #1;
    vectors++;
    if (fetch_ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL skip_ready_hb got %b exp 0", fetch_ready);
    end
    cycle;
    exp_v = {1'b1, 1'b1, 32'h102, 32'h0000_0000};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++; $display("[TB] FAIL skip_upper got %h exp %h", obs, exp_v);
    end
    cycle;
    exp_v = {1'b1, 1'b0, 32'h104, 32'h0000_0013};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++; $display("[TB] FAIL skip_follow got %h exp %h", obs, exp_v);
    end
    fetch_valid = 1'b0;
  endtask

  task automatic test_stall;
    do_reset;
    instr_ready = 1'b0; fetch_valid = 1'b1; fetch_word = 32'h4505_4501; fetch_pc = 32'h0;
    cycle;
    fetch_word = 32'h0000_0013; fetch_pc = 32'h4;
    exp_v = {1'b1, 1'b1, 32'h0, 32'h0000_4501};
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (fetch_ready !== 1'b0) begin
        miscompares++; $display("[TB] FAIL stall_ready[%0d] got %b exp 0", i, fetch_ready);
      end
      vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("[TB] FAIL stall_hold[%0d] got %h exp %h", i, obs, exp_v);
      end
      cycle;
    end
    instr_ready = 1'b1;
    cycle;
    exp_v = {1'b1, 1'b1, 32'h2, 32'h0000_4505};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++; $display("[TB] FAIL stall_release got %h exp %h", obs, exp_v);
    end
    cycle;
    exp_v = {1'b1, 1'b0, 32'h4, 32'h0000_0013};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++; $display("[TB] FAIL stall_no_loss got %h exp %h", obs, exp_v);
    end
    fetch_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset;
    instr_ready = 1'b0; fetch_valid = 1'b1; fetch_word = 32'h4505_4501; fetch_pc = 32'h0;
    cycle;
    reset = 1'b1; flush = 1'b1; flush_pc = 32'h2; fetch_valid = 1'b0;
    cycle;
    vectors++;
    if (instr_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rmid_valid got %b exp 0", instr_valid);
    end
    reset = 1'b0; flush = 1'b0; instr_ready = 1'b1; fetch_valid = 1'b1;
    fetch_word = 32'h0000_0013; fetch_pc = 32'h0;
    #1;
    vectors++;
    if ({fetch_ready, fetch_ready2} !== 2'b11) begin
      miscompares++; $display("[TB] FAIL rmid_ready got %b exp 11", {fetch_ready, fetch_ready2});
    end
    cycle;
    exp_v = {1'b1, 1'b0, 32'h0, 32'h0000_0013};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++; $display("[TB] FAIL rmid_hb_dropped got %h exp %h", obs, exp_v);
    end
    vectors++;
    if (instr_valid2 !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rpc2_skip got %b exp 0", instr_valid2);
    end
    fetch_valid = 1'b0;
    cycle;
    exp_v = {1'b1, 1'b1, 32'h2, 32'h0000_0000};
    vectors++;
    if (obs2 !== exp_v) begin
      miscompares++; $display("[TB] FAIL rpc2_upper got %h exp %h", obs2, exp_v);
    end
  endtask

  function automatic logic [15:0] rand_half();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
    return h;
  endfunction

  task automatic test_random;
    logic [15:0] hq[$];
    logic [31:0] pq[$];
    logic        skip;
    logic [31:0] wpc, cur_word;
    logic [15:0] h0, h1;
    logic [31:0] p0;
    do_reset;
    skip = 1'b0; wpc = 32'h0; cur_word = {rand_half(), rand_half()};
    for (int c = 0; c < 3000; c++) begin
      flush = ($urandom_range(0, 39) == 0);
      if (flush) flush_pc = {16'h0, 15'($urandom), 1'b0};
      fetch_valid = ($urandom_range(0, 3) != 0);
      fetch_word = cur_word; fetch_pc = wpc;
      instr_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (flush) begin
        hq.delete(); pq.delete();
        skip = flush_pc[1]; wpc = {flush_pc[31:2], 2'b00};
        cur_word = {rand_half(), rand_half()};
      end else begin
        if (instr_valid && instr_ready) begin
          vectors++;
          if (hq.size() == 0 || (hq[0][1:0] == 2'b11 && hq.size() < 2)) begin
            miscompares++; $display("[TB] FAIL rnd_underflow cycle %0d got %h exp none", c, obs);
          end else begin
            h0 = hq.pop_front(); p0 = pq.pop_front();
            if (h0[1:0] != 2'b11) begin
              exp_v = {1'b1, 1'b1, p0, 16'h0000, h0};
            end else begin
              h1 = hq.pop_front(); void'(pq.pop_front());
              exp_v = {1'b1, 1'b0, p0, h1, h0};
            end
            if (obs !== exp_v) begin
              miscompares++; $display("[TB] FAIL rnd_instr cycle %0d got %h exp %h", c, obs, exp_v);
            end
          end
        end
        if (fetch_valid && fetch_ready) begin
          if (!skip) begin
            hq.push_back(fetch_word[15:0]); pq.push_back({fetch_pc[31:2], 2'b00});
          end
          hq.push_back(fetch_word[31:16]); pq.push_back({fetch_pc[31:2], 2'b10});
          skip = 1'b0;
          wpc = wpc + 32'h4;
          cur_word = {rand_half(), rand_half()};
        end
      end
      cycle;
    end
    flush = 1'b0; fetch_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_uncompressed;
    test_compressed_pair;
    test_straddle;
    test_flush_skip;
    test_stall;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
